// File: rtl/sprite_blit_ctrl.sv
// Sprite blitter: walks a 16x16 sprite frame from character RAM
// and writes opaque, on-screen pixels into the framebuffer.
module sprite_blit_ctrl #(
  parameter int          FB_W      = 240,
  parameter int          FB_H      = 160,
  parameter int          SPR_DIM   = 16,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [8:0]  posX,
  input  logic [8:0]  posY,
  input  logic [1:0]  playerDir,
  output logic [18:0] char_addr,
  input  logic [23:0] char_data,
  output logic [18:0] fb_addr,
  output logic [23:0] fb_data,
  output logic        fb_we,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(SPR_DIM);
  localparam logic [9:0] FB_W10 = 10'(FB_W);
  localparam logic [9:0] FB_H10 = 10'(FB_H);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [8:0]    pos_x;
  logic [8:0]    pos_y;
  logic [1:0]    dir;

  logic [CW-1:0] nxt_col;
  logic [CW-1:0] nxt_row;
  logic          last_px;

  assign nxt_col = col + 1'b1;
  assign nxt_row = (&col) ? row + 1'b1 : row;
  assign last_px = (&row) && (&col);

  // char_addr is set on entry to RD so read data lands in WR
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      dir       <= '0;
      char_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pos_x     <= posX;
            pos_y     <= posY;
            dir       <= playerDir;
            row       <= '0;
            col       <= '0;
            char_addr <= 19'({playerDir, {(2*CW){1'b0}}});
            state     <= RD;
          end
        end
        RD: state <= WR;
        WR: begin
          col <= nxt_col;
          row <= nxt_row;
          if (last_px) begin
            state <= DONE;
          end else begin
            char_addr <= 19'({dir, nxt_row, nxt_col});
            state     <= RD;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [9:0]  px;
  logic [9:0]  py;
  logic [18:0] lin;
  logic        in_wr;
  logic        on_scr;
  logic        opaque;

  assign px     = {1'b0, pos_x} + 10'(col);
  assign py     = {1'b0, pos_y} + 10'(row);
  assign lin    = 19'(py) * 19'(FB_W) + 19'(px);
  assign in_wr  = (state == WR);
  assign on_scr = (px < FB_W10) && (py < FB_H10);
  assign opaque = (char_data != KEY_COLOR);

  assign fb_we   = in_wr && on_scr && opaque;
  assign fb_addr = in_wr ? lin : '0;
  assign fb_data = in_wr ? char_data : '0;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Scoreboard bench for sprite_blit_ctrl with a synchronous-read
// character RAM model and framebuffer write monitor.
module tb_sprite_blit_ctrl;

  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  posX = '0;
  logic [8:0]  posY = '0;
  logic [1:0]  playerDir = '0;
  logic [18:0] char_addr;
  logic [23:0] char_data;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;
  logic        fb_we;
  logic        busy;
  logic        done;

  always #5 Clk = ~Clk;

  sprite_blit_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .posX      (posX),
    .posY      (posY),
    .playerDir (playerDir),
    .char_addr (char_addr),
    .char_data (char_data),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_we     (fb_we),
    .busy      (busy),
    .done      (done)
  );

  logic [23:0] mem [0:1023];

  always @(posedge Clk) char_data <= mem[char_addr[9:0]];

  typedef struct {
    logic [18:0] a;
    logic [23:0] d;
  } wr_t;

  wr_t q[$];
  wr_t e;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt;
  int done_cnt;
  logic [18:0] ca_min, ca_max, fa_max;
  logic [18:0] first_a, last_a;
  logic [23:0] first_d, last_d;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (busy === 1'b1) begin
      if (char_addr < ca_min) ca_min = char_addr;
      if (char_addr > ca_max) ca_max = char_addr;
    end
    if (done === 1'b1) done_cnt++;
    if (fb_we === 1'b1) begin
      if (wr_cnt == 0) begin
        first_a = fb_addr;
        first_d = fb_data;
      end
      last_a = fb_addr;
      last_d = fb_data;
      if (fb_addr > fa_max) fa_max = fb_addr;
      wr_cnt++;
      vectors++;
      assert (q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_write: observed addr %0d expected none",
               fb_addr);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(e.a));
        chk("wr_data", 32'(fb_data), 32'(e.d));
      end
    end
  end

  task automatic clear_stats();
    wr_cnt   = 0;
    done_cnt = 0;
    ca_min   = '1;
    ca_max   = '0;
    fa_max   = '0;
  endtask

  task automatic push_expect(int x, int y, int d);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int px, py;
        logic [23:0] pix;
        px  = x + c;
        py  = y + r;
        pix = mem[d * 256 + r * 16 + c];
        if (pix != KEY && px < 240 && py < 160)
          q.push_back('{19'(py * 240 + px), pix});
      end
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_we"}, 32'(fb_we), 0);
    chk({tag, "_fa"}, 32'(fb_addr), 0);
    chk({tag, "_fd"}, 32'(fb_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // rst_at/poke_x/poke_s are cycle offsets from the start cycle; 0 = unused
  task automatic run(int x, int y, int d, int rst_at,
                     int pend, int poke_x, int poke_s);
    clear_stats();
    push_expect(x, y, d);
    @(negedge Clk);
    chk("idle_busy", 32'(busy), 0);
    posX      = 9'(x);
    posY      = 9'(y);
    playerDir = 2'(d);
    start     = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 513; i++) begin
      @(negedge Clk);
      if (i == rst_at) begin
        Reset_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        chk("rst_ca", 32'(char_addr), 0);
        chk("rst_pending", q.size(), pend);
        q.delete();
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        chk("post_rst_busy", 32'(busy), 0);
        return;
      end
      chk("busy", 32'(busy), 1);
      chk("done", 32'(done), (i == 513) ? 1 : 0);
      if (i == poke_x) posX = 9'(x + 37);
      if (i == poke_s) start = 1'b1;
      if (i == poke_s + 1) start = 1'b0;
    end
    #1;
    chk("pending", q.size(), 0);
    chk("done_cnt", done_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 24'(i);
      mem[256 + i] = 24'h010000 + 24'(i);
      mem[512 + i] = (((i >> 4) ^ i) & 1) != 0 ? 24'h123456 : KEY;
    end
    clear_stats();

    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      start = ~start;
      #1;
      chk_zero("in_rst");
      chk("in_rst_ca", 32'(char_addr), 0);
    end
    start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    chk("idle_busy0", 32'(busy), 0);
    chk("idle_wr", wr_cnt, 0);

    run(10, 20, 0, 0, 0, 0, 0);
    chk("basic_cnt", wr_cnt, 256);
    chk("basic_first_a", 32'(first_a), 4810);
    chk("basic_first_d", 32'(first_d), 0);
    chk("basic_last_a", 32'(last_a), 8425);
    chk("basic_last_d", 32'(last_d), 255);

    run(50, 60, 2, 0, 0, 0, 0);
    chk("dir2_cnt", wr_cnt, 128);
    chk("dir2_ca_min", 32'(ca_min), 512);
    chk("dir2_ca_max", 32'(ca_max), 767);

    run(232, 152, 1, 0, 0, 0, 0);
    chk("clip_cnt", wr_cnt, 64);
    chk("clip_max", 32'(fa_max), 38399);

    run(300, 10, 0, 0, 0, 0, 0);
    chk("offscr_cnt", wr_cnt, 0);

    run(10, 20, 0, 0, 0, 50, 100);
    chk("poke_cnt", wr_cnt, 256);
    run(100, 100, 0, 0, 0, 0, 0);
    chk("b2b_cnt", wr_cnt, 256);

    run(10, 20, 0, 301, 106, 0, 0);
    chk("rst_wr_cnt", wr_cnt, 150);
    chk("rst_no_done", done_cnt, 0);
    run(0, 0, 0, 0, 0, 0, 0);
    chk("after_rst_cnt", wr_cnt, 256);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_blit_ctrl.md
# sprite_blit_ctrl

Sequencer that composites the 16x16 player sprite into the 240x160 framebuffer once per trigger. It owns the read port of the character RAM and the write port of the framebuffer RAM. It walks the sprite for the selected facing direction and writes every non-transparent, on-screen pixel at the latched player position. It is started once per frame (vertical blank) by the top-level frame sequencer and reports busy/done back to it.

## Interface
- FB_W, 240, framebuffer width in pixels
- FB_H, 160, framebuffer height in pixels
- SPR_DIM, 16, sprite width and height in pixels (power of two)
- KEY_COLOR, 24'hFF00FF, transparent colour; pixels equal to it are not written
- Clk  in  1  system clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- posX  in  9  sprite top-left X (unsigned, may exceed FB_W)
- posY  in  9  sprite top-left Y (unsigned, may exceed FB_H)
- playerDir  in  2  sprite frame select (0..3)
- char_addr  out  19  character RAM read address, registered
- char_data  in  24  character RAM read data, valid 1 cycle after char_addr
- fb_addr  out  19  framebuffer write address
- fb_data  out  24  framebuffer write data
- fb_we  out  1  framebuffer write enable
- busy  out  1  high from first RD cycle through DONE
- done  out  1  one-cycle pulse in DONE

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: when start=1, latch posX, posY and playerDir, clear row/col counters (4 bits each), go to RD. Inputs changing after latch have no effect until the next start.
- RD: char_addr <= {dir,row,col} zero-extended, i.e. dir*256 + row*16 + col. Go to WR.
- WR: char_data holds the pixel. px = posX+col, py = posY+row, both computed 10 bits wide so no wrap.
  - fb_we = 1 iff char_data != KEY_COLOR and px < FB_W and py < FB_H.
  - fb_addr = py*FB_W + px, truncated to 19 bits (max 38399).
  - fb_data = char_data.
  - Then advance col; on col wrap advance row. If row=15 and col=15, go to DONE, else go to RD.
- DONE: done=1, busy=1, go to IDLE.
- start in RD/WR/DONE is ignored; it is not queued.
- fb_addr, fb_data and fb_we are combinational from registered state plus char_data. They are 0 in every state except WR.

## Timing
- Reset (async assert): state=IDLE, counters=0, latched regs=0, char_addr=0. fb_we, fb_addr, fb_data, busy and done are all 0 immediately.
- Reset mid-blit aborts. Pixels already written stay; no further writes occur. Release restarts in IDLE.
- Cycle T: start=1 in IDLE.
- Pixel k (0..255): RD at T+1+2k, WR at T+2+2k; the RAM captures the write at the edge ending T+2+2k.
- DONE at T+513; IDLE at T+514. busy is high T+1..T+513. A new start is accepted at T+514 at the earliest.
- Throughput is fixed at 2 cycles/pixel regardless of transparency or clipping.
- Clipping is per pixel. A sprite fully off-screen (posX>=240 or posY>=160) still runs 513 cycles with fb_we never asserted.

## Test plan
- Reset/idle: hold Reset_n=0 with start toggling -> all outputs 0. After release, no activity until start.
- Basic blit: sprite dir 0 fully opaque with pixel value = address index; posX=10, posY=20; start -> exactly 256 writes. The first is fb_addr=4810 with data 0, the last is fb_addr=8425 with data 255. done pulses at T+513.
- Transparency and direction: dir 2 with checkerboard KEY_COLOR/0x123456 -> 128 writes, all data 0x123456. char_addr spans 512..767.
- Clipping: posX=232, posY=152 -> only the 8x8 top-left quadrant is written (64 writes). Max fb_addr is 38399. No write with px>=240 or py>=160.
- Start while busy, and input change: pulse start at T+100 and change posX at T+50 -> ignored, writes keep the original posX, and there is a single done. A start at T+514 begins a new blit.
- Mid-op reset: assert Reset_n=0 at T+301 -> fb_we 0 at once, no writes after. After release, a fresh start completes a full 256-pixel blit.
